// File: rtl/sel_mux_pipe.sv
//----------------------------------------------------------------------------
// sel_mux_pipe
//
// Registered N-way datapath selector with a valid/ready handshake and a
// 2-entry skid buffer (output register OR + skid register SK). Each accepted
// transaction selects channel in_sel of in_bus. An out-of-range select
// produces zero data with out_err set. The select is carried through as it
// was presented.
//
// Optional feature macro: SEL_MUX_ERR_CNT_EN
//   When defined, the err_cnt port exists and counts accepts with an
//   out-of-range select. The count saturates at 255 and is cleared only by
//   reset. When undefined, the port and counter are absent.
//
// Parameters:
//   WIDTH   bits per channel
//   NUM_IN  number of channels (2..16)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//
// Ports:
//   Clk        clock, rising edge
//   Reset_n    asynchronous active-low reset
//   in_bus     flattened channels, channel k = in_bus[k*WIDTH +: WIDTH]
//   in_sel     channel index
//   in_valid   upstream transaction present
//   in_ready   block can accept (decoded from state only)
//   out_data   selected, registered data
//   out_sel    select that produced out_data
//   out_err    in_sel was >= NUM_IN for this transaction
//   out_valid  out_data/out_sel/out_err valid
//   out_ready  downstream accepts
//   err_cnt    saturating out-of-range count (SEL_MUX_ERR_CNT_EN only)
//   dbg_state  current FSM state (0=EMPTY, 1=ONE, 2=FULL)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid never depends on ready. in_ready depends on state only,
// so there is no combinational path from out_ready to in_ready.
//----------------------------------------------------------------------------
module sel_mux_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef SEL_MUX_ERR_CNT_EN
    output logic [7:0]              err_cnt,
`endif
    output logic [1:0]              dbg_state
);

    // One stored transaction: {data, sel, err}
    localparam int ENT_W = WIDTH + SEL_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ENT_W-1:0]  or_q, sk_q, new_entry;
    logic [WIDTH-1:0]  new_data;
    logic              sel_ok;
    logic              accept, deliver;
    logic              or_load_in, or_load_sk, sk_load;

    // Selection. Codes with no matching channel (including the unused codes
    // when NUM_IN is not a power of two) leave sel_ok low and data zero.
    always_comb begin
        new_data = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                new_data = in_bus[k*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    assign new_entry = {new_data, in_sel, ~sel_ok};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // Next state and register load controls
    always_comb begin
        state_nxt  = state;
        or_load_in = 1'b0;
        or_load_sk = 1'b0;
        sk_load    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt  = ONE;
                    or_load_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    or_load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    sk_load   = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // No accept possible here: in_ready is low
                if (deliver) begin
                    state_nxt  = ONE;
                    or_load_sk = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= EMPTY;
            or_q  <= '0;
            sk_q  <= '0;
        end else begin
            state <= state_nxt;
            if (or_load_in) begin
                or_q <= new_entry;
            end else if (or_load_sk) begin
                or_q <= sk_q;
            end
            if (sk_load) begin
                sk_q <= new_entry;
            end
        end
    end

    assign out_data  = or_q[ENT_W-1 -: WIDTH];
    assign out_sel   = or_q[SEL_W:1];
    assign out_err   = or_q[0];
    assign dbg_state = state;

`ifdef SEL_MUX_ERR_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt <= 8'd0;
        end else if (accept && !sel_ok && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
//----------------------------------------------------------------------------
// tb_sel_mux_pipe
//
// Directed vectors with hand-computed expectations for the default 4-channel
// configuration plus a 3-channel instance for out-of-range selects, then a
// random valid/ready run checked against an expected queue.
//----------------------------------------------------------------------------
module tb_sel_mux_pipe;

    //------------------------------------------------------------------
    // Clock / reset
    //------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    //------------------------------------------------------------------
    // DUT 4-channel
    //------------------------------------------------------------------
    logic [31:0] in_bus;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  dbg_state;
`ifdef SEL_MUX_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    sel_mux_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .in_bus    (in_bus),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SEL_MUX_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .dbg_state (dbg_state)
    );

    //------------------------------------------------------------------
    // DUT 3-channel (non power-of-two: code 3 is out of range)
    //------------------------------------------------------------------
    logic [23:0] in_bus3;
    logic [1:0]  in_sel3;
    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_err3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  dbg_state3;
`ifdef SEL_MUX_ERR_CNT_EN
    logic [7:0]  err_cnt3;
`endif

    sel_mux_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .in_bus    (in_bus3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
`ifdef SEL_MUX_ERR_CNT_EN
        .err_cnt   (err_cnt3),
`endif
        .dbg_state (dbg_state3)
    );

    //------------------------------------------------------------------
    // Scoreboard state and checking
    //------------------------------------------------------------------
    int          n_checks;
    int          n_errors;
    logic [10:0] exp_q[$];   // {data, sel, err}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] chan_of(input logic [31:0] bus, input logic [1:0] sel);
        logic [7:0] r;
        r = bus[sel*8 +: 8];
        return r;
    endfunction

    //------------------------------------------------------------------
    // Driver tasks
    //------------------------------------------------------------------
    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic vld, input logic rdy);
        in_sel    = sel;
        in_valid  = vld;
        out_ready = rdy;
    endtask

    //------------------------------------------------------------------
    // Stimulus
    //------------------------------------------------------------------
    logic [7:0] exp_chan [4];
    logic       can_acc;
    logic [1:0] rsel;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_chan   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst_n      = 1'b0;
        in_bus     = 32'hDDCC_BBAA;
        in_sel     = 2'd0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_bus3    = 24'hCC_BBAA;
        in_sel3    = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;

        // Reset values
        #17;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_data",  out_data,  0);
        check("rst_out_sel",   out_sel,   0);
        check("rst_out_err",   out_err,   0);
        check("rst_state",     dbg_state, 0);
        rst_n = 1'b1;

        // Single transaction, sel=2
        drive(2'd2, 1'b1, 1'b1);
        step();
        check("single_data",  out_data,  8'hCC);
        check("single_sel",   out_sel,   2);
        check("single_err",   out_err,   0);
        check("single_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("single_drain", out_valid, 0);

        // Streaming 0..3 with out_ready high
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 1'b1, 1'b1);
            step();
            check("stream_data",  out_data,  exp_chan[i]);
            check("stream_sel",   out_sel,   i);
            check("stream_ready", in_ready,  1);
            check("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", out_valid, 0);

        // Stall: fill the skid buffer, then release
        drive(2'd0, 1'b1, 1'b0);
        step();
        check("stall1_ready", in_ready,  1);
        check("stall1_data",  out_data,  8'hAA);
        drive(2'd1, 1'b1, 1'b0);
        step();
        check("stall2_ready", in_ready,  0);
        check("stall2_data",  out_data,  8'hAA);
        check("stall2_state", dbg_state, 2);
        // Inputs change while full must not disturb the held data
        drive(2'd3, 1'b1, 1'b0);
        step();
        check("hold_data",  out_data, 8'hAA);
        check("hold_ready", in_ready, 0);
        drive(2'd0, 1'b0, 1'b1);
        check("deliver_a",  out_data, 8'hAA);
        step();
        check("deliver_b",  out_data,  8'hBB);
        check("deliver_b_sel", out_sel, 1);
        check("ready_back", in_ready,  1);
        check("valid_b",    out_valid, 1);
        step();
        check("stall_drain", out_valid, 0);

        // Three-channel instance: in range and out of range
        in_sel3   = 2'd2;
        in_valid3 = 1'b1;
        step();
        check("n3_data2", out_data3, 8'hCC);
        check("n3_err2",  out_err3,  0);
        in_sel3 = 2'd3;
        step();
        check("n3_data3", out_data3, 0);
        check("n3_err3",  out_err3,  1);
        check("n3_sel3",  out_sel3,  3);
        check("n3_valid", out_valid3, 1);
`ifdef SEL_MUX_ERR_CNT_EN
        check("n3_cnt1", err_cnt3, 1);
        repeat (300) step();
        check("n3_cnt_sat", err_cnt3, 255);
        check("n4_cnt0",    err_cnt,  0);
`endif
        in_valid3 = 1'b0;
        step();
        check("n3_drain", out_valid3, 0);

        // Asynchronous reset while full
        drive(2'd0, 1'b1, 1'b0);
        step();
        drive(2'd1, 1'b1, 1'b0);
        step();
        check("pre_rst_state", dbg_state, 2);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready,  1);
        check("arst_data",  out_data,  0);
        check("arst_state", dbg_state, 0);
`ifdef SEL_MUX_ERR_CNT_EN
        check("arst_cnt",   err_cnt3,  0);
`endif
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_valid", out_valid, 0);
        drive(2'd3, 1'b1, 1'b1);
        step();
        check("post_rst_data",  out_data,  8'hDD);
        check("post_rst_sel",   out_sel,   3);
        in_valid = 1'b0;
        step();
        check("post_rst_empty", out_valid, 0);

        // Random valid/ready run against the expected queue
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rsel      = 2'($urandom_range(0, 3));
            in_sel    = rsel;
            in_bus    = $urandom();
            check("rnd_valid", out_valid, (exp_q.size() != 0));
            check("rnd_ready", in_ready,  (exp_q.size() < 2));
            can_acc = (exp_q.size() < 2);
            if (exp_q.size() != 0 && out_ready) begin
                check("rnd_entry", {out_data, out_sel, out_err}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (in_valid && can_acc) begin
                exp_q.push_back({chan_of(in_bus, rsel), rsel, 1'b0});
            end
            step();
        end

        // Drain whatever remains
        drive(2'd0, 1'b0, 1'b1);
        for (int d = 0; d < 3; d++) begin
            if (exp_q.size() != 0) begin
                check("drain_valid", out_valid, 1);
                check("drain_entry", {out_data, out_sel, out_err}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            step();
        end
        check("drain_empty", out_valid, 0);

        // Final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
